// File: rtl/hazard3_ahb_sram_excl.sv
// ---------------------------------------------------------------------------
// hazard3_ahb_sram_excl
//
// AHB5 subordinate wrapping a word-organised SRAM. It adds an exclusive
// access monitor (hexcl/hexokay) and a programmable number of wait states.
//
// Ports:
//   clk, rst          clock and synchronous active-high reset
//   hsel, haddr,      address-phase inputs. A transfer is accepted when
//   hwrite, htrans,   hsel && htrans[1] && hready.
//   hsize, hexcl,
//   hmaster
//   hready            global bus ready
//   hwdata            write data, sampled in the final data-phase cycle
//   hreadyout, hresp  responder handshake (two-cycle ERROR response)
//   hexokay           exclusive success, valid only in the DONE cycle
//   hrdata            read data, valid only in the DONE cycle of a read
// ---------------------------------------------------------------------------
module hazard3_ahb_sram_excl #(
    parameter int W_ADDR      = 32,
    parameter int W_DATA      = 32,
    parameter int DEPTH       = 1024,
    parameter int WAIT_STATES = 0
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              hsel,
    input  logic [W_ADDR-1:0] haddr,
    input  logic              hwrite,
    input  logic [1:0]        htrans,
    input  logic [2:0]        hsize,
    input  logic              hexcl,
    input  logic [7:0]        hmaster,
    input  logic              hready,
    output logic              hreadyout,
    output logic              hresp,
    output logic              hexokay,
    input  logic [W_DATA-1:0] hwdata,
    output logic [W_DATA-1:0] hrdata
);

    localparam int IDX_W = $clog2(DEPTH);
    localparam logic [3:0] WS_LOAD = 4'((WAIT_STATES > 0) ? WAIT_STATES - 1 : 0);

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_WAIT,
        ST_DONE,
        ST_ERR1,
        ST_ERR2
    } state_t;

    state_t            state_q, state_d;
    logic [3:0]        cnt_q, cnt_d;
    logic [IDX_W-1:0]  idx_q, idx_d;
    logic [1:0]        lane_q, lane_d;
    logic [1:0]        size_q, size_d;
    logic              write_q, write_d;
    logic              excl_q, excl_d;
    logic [7:0]        master_q, master_d;
    logic              resv_valid_q, resv_valid_d;
    logic [IDX_W-1:0]  resv_idx_q, resv_idx_d;
    logic [7:0]        resv_master_q, resv_master_d;
    logic [W_DATA-1:0] rdata_q, rdata_d;

    logic [W_DATA-1:0] mem [DEPTH];

    logic              can_accept, accept, bad;
    logic              in_done, excl_ok, commit;
    logic [3:0]        wstrb;
    logic [IDX_W-1:0]  rd_idx;
    logic [W_DATA-1:0] mem_rd;

    // htrans[0] only distinguishes NSEQ from SEQ, which this block ignores.
    logic unused_bits;
    assign unused_bits = htrans[0];

    // New transfers are only taken when no data phase is stalling the bus.
    assign can_accept = (state_q == ST_IDLE) || (state_q == ST_DONE) || (state_q == ST_ERR2);
    assign accept     = hsel && htrans[1] && hready && can_accept;
    assign bad        = ({2'b00, haddr[W_ADDR-1:2]} >= W_ADDR'(DEPTH))
                      || (hsize > 3'd2)
                      || (hsize == 3'd1 && haddr[0])
                      || (hsize == 3'd2 && haddr[1:0] != 2'b00);

    assign in_done = (state_q == ST_DONE);
    assign excl_ok = resv_valid_q && (resv_idx_q == idx_q) && (resv_master_q == master_q);
    assign commit  = in_done && write_q && (!excl_q || excl_ok) && !rst;

    // Byte-lane strobes for the committing write, from latched size and lane.
    always_comb begin
        wstrb = 4'b0000;
        case (size_q)
            2'd0:    wstrb = 4'b0001 << lane_q;
            2'd1:    wstrb = lane_q[1] ? 4'b1100 : 4'b0011;
            default: wstrb = 4'b1111;
        endcase
    end

    // Read data is captured on the edge that enters DONE. When a write commits
    // on that same edge (zero-wait back-to-back), its bytes are forwarded so
    // the read observes it.
    always_comb begin
        rd_idx  = accept ? haddr[IDX_W+1:2] : idx_q;
        mem_rd  = mem[rd_idx];
        rdata_d = mem_rd;
        if (commit && (idx_q == rd_idx)) begin
            for (int b = 0; b < 4; b++) begin
                if (wstrb[b]) rdata_d[8*b +: 8] = hwdata[8*b +: 8];
            end
        end
    end

    // Responder FSM: next state and latching of the address phase.
    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        idx_d    = idx_q;
        lane_d   = lane_q;
        size_d   = size_q;
        write_d  = write_q;
        excl_d   = excl_q;
        master_d = master_q;
        case (state_q)
            ST_WAIT: begin
                if (cnt_q == 4'd0) state_d = ST_DONE;
                else               cnt_d   = cnt_q - 4'd1;
            end
            ST_ERR1: state_d = ST_ERR2;
            default: begin
                state_d = ST_IDLE;
                if (accept) begin
                    idx_d    = haddr[IDX_W+1:2];
                    lane_d   = haddr[1:0];
                    size_d   = hsize[1:0];
                    write_d  = hwrite;
                    excl_d   = hexcl;
                    master_d = hmaster;
                    if (bad) begin
                        state_d = ST_ERR1;
                    end else if (WAIT_STATES > 0) begin
                        state_d = ST_WAIT;
                        cnt_d   = WS_LOAD;
                    end else begin
                        state_d = ST_DONE;
                    end
                end
            end
        endcase
    end

    // Reservation monitor, updated only by transfers completing in DONE.
    always_comb begin
        resv_valid_d  = resv_valid_q;
        resv_idx_d    = resv_idx_q;
        resv_master_d = resv_master_q;
        if (in_done) begin
            if (excl_q && !write_q) begin
                resv_valid_d  = 1'b1;
                resv_idx_d    = idx_q;
                resv_master_d = master_q;
            end else if (write_q && (excl_q || idx_q == resv_idx_q)) begin
                resv_valid_d = 1'b0;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q       <= ST_IDLE;
            cnt_q         <= 4'd0;
            idx_q         <= '0;
            lane_q        <= 2'd0;
            size_q        <= 2'd0;
            write_q       <= 1'b0;
            excl_q        <= 1'b0;
            master_q      <= 8'd0;
            resv_valid_q  <= 1'b0;
            resv_idx_q    <= '0;
            resv_master_q <= 8'd0;
            rdata_q       <= '0;
        end else begin
            state_q       <= state_d;
            cnt_q         <= cnt_d;
            idx_q         <= idx_d;
            lane_q        <= lane_d;
            size_q        <= size_d;
            write_q       <= write_d;
            excl_q        <= excl_d;
            master_q      <= master_d;
            resv_valid_q  <= resv_valid_d;
            resv_idx_q    <= resv_idx_d;
            resv_master_q <= resv_master_d;
            rdata_q       <= rdata_d;
        end
    end

    // Memory array is not reset; commit already excludes reset cycles.
    always_ff @(posedge clk) begin
        if (commit) begin
            for (int b = 0; b < 4; b++) begin
                if (wstrb[b]) mem[idx_q][8*b +: 8] <= hwdata[8*b +: 8];
            end
        end
    end

    assign hreadyout = !((state_q == ST_WAIT) || (state_q == ST_ERR1));
    assign hresp     = (state_q == ST_ERR1) || (state_q == ST_ERR2);
    assign hexokay   = in_done && excl_q && (!write_q || excl_ok);
    assign hrdata    = (in_done && !write_q) ? rdata_q : '0;

endmodule
